// File: rtl/multiplier_pkg.sv
// Shared definitions for the shift-add multiplier: register widths and the
// running-sum operation selected from the control strobes.
package multiplier_pkg;

  function automatic int RS_WIDTH(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int PROD_WIDTH(input int w);
    return 2 * w;
  endfunction

  typedef enum logic [1:0] {
    RS_HOLD  = 2'd0,
    RS_CLEAR = 2'd1,
    RS_LOAD  = 2'd2,
    RS_SHR   = 2'd3
  } rs_op_e;

  // Strobes never overlap in normal operation; clear wins, then load, then shift.
  function automatic rs_op_e rs_op_sel(input logic clear, input logic load, input logic shr);
    if (clear)     return RS_CLEAR;
    else if (load) return RS_LOAD;
    else if (shr)  return RS_SHR;
    else           return RS_HOLD;
  endfunction

endpackage

// File: rtl/taint_load_reg.sv
// Value register with load enable and a sticky taint bit that only reset clears.
module taint_load_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         ld_t,
  input  logic [W-1:0] d,
  input  logic         d_t,
  output logic [W-1:0] q,
  output logic         q_t
);

  logic [W-1:0] q_reg;
  logic         q_t_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg   <= '0;
      q_t_reg <= 1'b0;
    end else begin
      if (ld) q_reg <= d;
      // A tainted strobe taints the register even when it does not load.
      q_t_reg <= q_t_reg | ld_t | (ld & d_t);
    end
  end

  assign q   = q_reg;
  assign q_t = q_t_reg;

endmodule

// File: rtl/multiplier_datapath_taint_track_word.sv
// Shift-add multiplier datapath: operand registers, running sum with carry bit,
// and word-level sticky taint for each register.
module multiplier_datapath_taint_track_word
  import multiplier_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      multiplicandIn,
  input  logic                  multiplicandIn_t,
  input  logic [WIDTH-1:0]      multiplierIn,
  input  logic                  multiplierIn_t,
  input  logic                  mdld,
  input  logic                  mdld_t,
  input  logic                  mrld,
  input  logic                  mrld_t,
  input  logic                  rsclear,
  input  logic                  rsclear_t,
  input  logic                  rsload,
  input  logic                  rsload_t,
  input  logic                  rsshr,
  input  logic                  rsshr_t,
  output logic [WIDTH-1:0]      multiplierReg,
  output logic                  multiplierReg_t,
  output logic [2*WIDTH-1:0]    product,
  output logic                  product_t
);

  localparam int RSW = RS_WIDTH(WIDTH);
  localparam int PW  = PROD_WIDTH(WIDTH);

  logic [WIDTH-1:0] md_reg;
  logic             md_t_reg;
  logic [RSW-1:0]   rs_reg;
  logic [RSW-1:0]   rs_next;
  logic             rs_t_reg;
  rs_op_e           rs_op;

  taint_load_reg #(.W(WIDTH)) u_md (
    .clk  (clk),
    .rst  (rst),
    .ld   (mdld),
    .ld_t (mdld_t),
    .d    (multiplicandIn),
    .d_t  (multiplicandIn_t),
    .q    (md_reg),
    .q_t  (md_t_reg)
  );

  taint_load_reg #(.W(WIDTH)) u_mr (
    .clk  (clk),
    .rst  (rst),
    .ld   (mrld),
    .ld_t (mrld_t),
    .d    (multiplierIn),
    .d_t  (multiplierIn_t),
    .q    (multiplierReg),
    .q_t  (multiplierReg_t)
  );

  assign rs_op = rs_op_sel(rsclear, rsload, rsshr);

  // The upper-half add is WIDTH+1 bits wide so its carry lands in the top rs bit.
  always_comb begin
    rs_next = rs_reg;
    case (rs_op)
      RS_CLEAR: rs_next = '0;
      RS_LOAD:  rs_next = {rs_reg[RSW-1:WIDTH] + {1'b0, md_reg}, rs_reg[WIDTH-1:0]};
      RS_SHR:   rs_next = {1'b0, rs_reg[RSW-1:1]};
      default:  rs_next = rs_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs_reg   <= '0;
      rs_t_reg <= 1'b0;
    end else begin
      rs_reg   <= rs_next;
      // rsclear zeroes the value but deliberately leaves the taint sticky.
      rs_t_reg <= rs_t_reg | rsclear_t | rsshr_t | rsload_t | (rsload & md_t_reg);
    end
  end

  assign product   = rs_reg[PW-1:0];
  assign product_t = rs_t_reg;

endmodule

// File: tb/tb_multiplier_datapath_taint_track_word.sv
// Randomized scoreboard bench: the driver models each strobe arithmetically and
// queues expectations; a monitor compares them one cycle after the strobe.
module tb_multiplier_datapath_taint_track_word;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [W-1:0]   multiplicandIn = '0;
  logic           multiplicandIn_t = 1'b0;
  logic [W-1:0]   multiplierIn = '0;
  logic           multiplierIn_t = 1'b0;
  logic           mdld = 1'b0, mdld_t = 1'b0, mrld = 1'b0, mrld_t = 1'b0;
  logic           rsclear = 1'b0, rsclear_t = 1'b0, rsload = 1'b0, rsload_t = 1'b0;
  logic           rsshr = 1'b0, rsshr_t = 1'b0;
  logic [W-1:0]   multiplierReg;
  logic           multiplierReg_t;
  logic [2*W-1:0] product;
  logic           product_t;

  always #5 clk = ~clk;

  multiplier_datapath_taint_track_word #(.WIDTH(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .multiplicandIn   (multiplicandIn),
    .multiplicandIn_t (multiplicandIn_t),
    .multiplierIn     (multiplierIn),
    .multiplierIn_t   (multiplierIn_t),
    .mdld             (mdld),
    .mdld_t           (mdld_t),
    .mrld             (mrld),
    .mrld_t           (mrld_t),
    .rsclear          (rsclear),
    .rsclear_t        (rsclear_t),
    .rsload           (rsload),
    .rsload_t         (rsload_t),
    .rsshr            (rsshr),
    .rsshr_t          (rsshr_t),
    .multiplierReg    (multiplierReg),
    .multiplierReg_t  (multiplierReg_t),
    .product          (product),
    .product_t        (product_t)
  );

  typedef struct packed {
    bit r, mdl, mdl_t, mrl, mrl_t, clr, clr_t, ld, ld_t, sh, sh_t;
  } ctl_t;

  typedef struct {
    int prod;
    int prod_t;
    int mreg;
    int mreg_t;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  bit   req = 1'b0;
  bit   req_q = 1'b0;

  // Reference state: plain integers following the strobe rules.
  int m_md = 0, m_mr = 0, m_rs = 0;
  bit m_md_t = 0, m_mr_t = 0, m_rs_t = 0;

  task automatic check(input string name, input int act, input int req_v);
    total++;
    if (act != req_v) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req_v, $time);
    end
  endtask

  // Drive one cycle of strobes; if chk, queue the state expected after the edge.
  task automatic cycle(input ctl_t c, input int a, input int b, input bit a_t, input bit b_t,
                       input bit chk, input int final_prod);
    int n_md, n_mr, n_rs;
    bit n_md_t, n_mr_t, n_rs_t;
    exp_t e;
    @(negedge clk);
    rst = c.r;
    multiplicandIn = a[W-1:0];  multiplicandIn_t = a_t;
    multiplierIn   = b[W-1:0];  multiplierIn_t   = b_t;
    mdld = c.mdl;    mdld_t = c.mdl_t;
    mrld = c.mrl;    mrld_t = c.mrl_t;
    rsclear = c.clr; rsclear_t = c.clr_t;
    rsload = c.ld;   rsload_t = c.ld_t;
    rsshr = c.sh;    rsshr_t = c.sh_t;
    if (c.r) begin
      n_md = 0; n_mr = 0; n_rs = 0; n_md_t = 0; n_mr_t = 0; n_rs_t = 0;
    end else begin
      n_md   = c.mdl ? a : m_md;
      n_mr   = c.mrl ? b : m_mr;
      n_md_t = m_md_t | c.mdl_t | (c.mdl & a_t);
      n_mr_t = m_mr_t | c.mrl_t | (c.mrl & b_t);
      n_rs_t = m_rs_t | c.clr_t | c.sh_t | c.ld_t | (c.ld & m_md_t);
      if (c.clr)     n_rs = 0;
      else if (c.ld) n_rs = (m_rs + m_md * (1 << W)) % (1 << (2 * W + 1));
      else if (c.sh) n_rs = m_rs / 2;
      else           n_rs = m_rs;
    end
    m_md = n_md; m_mr = n_mr; m_rs = n_rs;
    m_md_t = n_md_t; m_mr_t = n_mr_t; m_rs_t = n_rs_t;
    req = chk;
    if (chk) begin
      e.prod   = (final_prod >= 0) ? final_prod : (m_rs % (1 << (2 * W)));
      e.prod_t = int'(m_rs_t);
      e.mreg   = m_mr;
      e.mreg_t = int'(m_mr_t);
      sb.push_back(e);
    end
  endtask

  task automatic idle(input bit chk);
    cycle('0, 0, 0, 1'b0, 1'b0, chk, -1);
  endtask

  task automatic do_reset();
    ctl_t c;
    c = '0; c.r = 1'b1;
    cycle(c, 0, 0, 1'b0, 1'b0, 1'b1, -1);
  endtask

  // One controller sequence: load, clear, W+1 shifts with loads on set multiplier bits.
  task automatic run(input int a, input int b, input bit a_t, input bit b_t,
                     input int tpulse, input int rst_after);
    ctl_t c;
    $display("run md=%0d mr=%0d md_t=%0d mr_t=%0d shr_t_at=%0d rst_at=%0d",
             a, b, a_t, b_t, tpulse, rst_after);
    c = '0; c.mdl = 1'b1; c.mrl = 1'b1;
    cycle(c, a, b, a_t, b_t, 1'b1, -1);
    c = '0; c.clr = 1'b1;
    cycle(c, 0, 0, 1'b0, 1'b0, 1'b1, -1);
    for (int s = 0; s <= W; s++) begin
      if (s == rst_after) begin
        c = '0; c.r = 1'b1; c.ld = 1'b1; c.sh = 1'b1;
        cycle(c, 0, 0, 1'b0, 1'b0, 1'b1, -1);
        return;
      end
      c = '0; c.sh = 1'b1; c.sh_t = (s == tpulse);
      cycle(c, 0, 0, 1'b0, 1'b0, 1'b1, (s == W) ? a * b : -1);
      if (s < W && ((b >> s) & 1) == 1) begin
        c = '0; c.ld = 1'b1;
        cycle(c, 0, 0, 1'b0, 1'b0, 1'b1, -1);
      end
    end
  endtask

  always @(posedge clk) req_q <= req;

  always @(negedge clk) begin
    exp_t e;
    if (req_q) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_underflow actual=empty required=entry t=%0t", $time);
      end else begin
        e = sb.pop_front();
        check("product", int'(product), e.prod);
        check("product_t", int'(product_t), e.prod_t);
        check("multiplierReg", int'(multiplierReg), e.mreg);
        check("multiplierReg_t", int'(multiplierReg_t), e.mreg_t);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    run(13, 11, 1'b0, 1'b0, -1, -1);
    run(15, 15, 1'b0, 1'b0, -1, -1);
    run(9, 0, 1'b0, 1'b0, -1, -1);
    do_reset();
    run(13, 4, 1'b1, 1'b0, -1, -1);
    do_reset();
    run(13, 0, 1'b1, 1'b0, -1, -1);
    do_reset();
    run(6, 7, 1'b0, 1'b1, -1, -1);
    do_reset();
    run(11, 9, 1'b0, 1'b0, 2, -1);
    run(13, 11, 1'b0, 1'b0, -1, -1);
    run(12, 10, 1'b1, 1'b1, -1, 2);
    run(7, 9, 1'b0, 1'b0, -1, -1);
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(1, 0) == 1) do_reset();
      run(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
          ($urandom_range(7, 0) == 0), ($urandom_range(7, 0) == 0),
          ($urandom_range(5, 0) == 0) ? int'($urandom_range(W, 0)) : -1,
          ($urandom_range(9, 0) == 0) ? int'($urandom_range(W, 1)) : -1);
    end
    idle(1'b1);
    idle(1'b0);
    idle(1'b0);
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
